// File: rtl/clock_step_controller_if.sv
// clock_step_controller_if
//   Command channel of the CPU run-control sequencer.
//   master : issues commands (cmd_valid, cmd_op, cmd_count), observes cmd_ready
//   slave  : the sequencer; accepts on a rising edge when cmd_valid && cmd_ready
//   cmd_op : 00 HALT, 01 STEP, 10 RUN, 11 RUN_N (cmd_count = tick count)
interface clock_step_controller_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;

    modport master (output cmd_valid, cmd_op, cmd_count, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_count, output cmd_ready);
endinterface

// File: rtl/clock_step_controller.sv
// clock_step_controller
//   Run-control sequencer for the CPU clock. The clock itself is never gated;
//   the block issues a registered tick enable (clk_en) that CPU registers use
//   to qualify their updates. Commands: HALT, STEP, RUN, RUN_N.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   cmd          command channel (slave modport of clock_step_controller_if)
//   cpu_halt     CPU halt request, honoured only while active
//   clk_en       registered tick enable
//   running      high in any active state
//   done         one-cycle pulse on every active-to-HALTED transition
//   remaining    ticks left in RUN_N, 0 otherwise
//   cycle_count  number of cycles with clk_en high (wraps)
//
// Optional feature, macro CLOCK_STEP_BREAKPOINT_EN:
//   bp_en, bp_addr, pc inputs and sticky bp_hit output. In RUN/RUN_N a
//   match of pc against bp_addr stops the sequencer like cpu_halt.
//
// state    | meaning
// S_HALTED | idle, no ticks, any command accepted
// S_STEP   | single tick in flight, commands back-pressured
// S_RUN    | ticking every cycle until a stop event
// S_RUN_N  | ticking until remaining reaches 0 or a stop event
module clock_step_controller #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    clock_step_controller_if.slave cmd,
    input  logic                   cpu_halt,
`ifdef CLOCK_STEP_BREAKPOINT_EN
    input  logic                   bp_en,
    input  logic [15:0]            bp_addr,
    input  logic [15:0]            pc,
    output logic                   bp_hit,
`endif
    output logic                   clk_en,
    output logic                   running,
    output logic                   done,
    output logic [CNT_W-1:0]       remaining,
    output logic [CYC_W-1:0]       cycle_count
);
    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_RUN_N = 2'b11;

    typedef enum logic [1:0] {S_HALTED, S_STEP, S_RUN, S_RUN_N} state_t;

    state_t           state_q, state_d;
    logic             clk_en_q, clk_en_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CYC_W-1:0] cyc_q;
    logic             accept, start, halt_cmd, bp_stop, stop;

    // Only HALT may interrupt a free or counted run; STEP takes nothing.
    assign cmd.cmd_ready = (state_q == S_HALTED) ||
                           (((state_q == S_RUN) || (state_q == S_RUN_N)) && (cmd.cmd_op == OP_HALT));

    assign accept   = cmd.cmd_valid && cmd.cmd_ready;
    assign start    = accept && (state_q == S_HALTED) && (cmd.cmd_op != OP_HALT);
    assign halt_cmd = accept && (state_q != S_HALTED) && (cmd.cmd_op == OP_HALT);

`ifdef CLOCK_STEP_BREAKPOINT_EN
    logic first_q, bp_hit_q;

    // first_q masks the compare at the edge ending the first tick, so a run
    // started on the breakpoint address always makes progress.
    assign bp_stop = bp_en && (pc == bp_addr) && !first_q &&
                     ((state_q == S_RUN) || (state_q == S_RUN_N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q  <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            first_q <= start;
            if (start)
                bp_hit_q <= 1'b0;
            else if (bp_stop)
                bp_hit_q <= 1'b1;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    assign bp_stop = 1'b0;
`endif

    assign stop = halt_cmd || cpu_halt || bp_stop;

    always_comb begin
        state_d  = state_q;
        clk_en_d = 1'b0;
        done_d   = 1'b0;
        rem_d    = rem_q;
        case (state_q)
            S_HALTED: begin
                rem_d = '0;
                if (start) begin
                    case (cmd.cmd_op)
                        OP_STEP: begin
                            state_d  = S_STEP;
                            clk_en_d = 1'b1;
                        end
                        OP_RUN: begin
                            state_d  = S_RUN;
                            clk_en_d = 1'b1;
                        end
                        OP_RUN_N: begin
                            state_d  = S_RUN_N;
                            rem_d    = cmd.cmd_count;
                            clk_en_d = (cmd.cmd_count != '0);
                        end
                        default: ;
                    endcase
                end
            end
            S_STEP: begin
                state_d = S_HALTED;
                done_d  = 1'b1;
                rem_d   = '0;
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_HALTED;
                    done_d  = 1'b1;
                end else begin
                    clk_en_d = 1'b1;
                end
            end
            default: begin
                // remaining 1 means the last tick ends at this edge; 0 only
                // occurs for a zero-length run that never ticked.
                if (stop || (rem_q <= CNT_W'(1))) begin
                    state_d = S_HALTED;
                    done_d  = 1'b1;
                    rem_d   = '0;
                end else begin
                    rem_d    = rem_q - CNT_W'(1);
                    clk_en_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HALTED;
            clk_en_q <= 1'b0;
            done_q   <= 1'b0;
            rem_q    <= '0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            clk_en_q <= clk_en_d;
            done_q   <= done_d;
            rem_q    <= rem_d;
            cyc_q    <= cyc_q + CYC_W'(clk_en_q);
        end
    end

    assign clk_en      = clk_en_q;
    assign running     = (state_q != S_HALTED);
    assign done        = done_q;
    assign remaining   = rem_q;
    assign cycle_count = cyc_q;
endmodule

// File: tb/tb_clock_step_controller.sv
module tb_clock_step_controller;
    localparam int CNT_W = 16;
    localparam int CYC_W = 32;
    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_STEP  = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;
    localparam logic [1:0] OP_RUN_N = 2'd3;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             cpu_halt = 1'b0;
    logic             clk_en, running, done;
    logic [CNT_W-1:0] remaining;
    logic [CYC_W-1:0] cycle_count;
`ifdef CLOCK_STEP_BREAKPOINT_EN
    logic             bp_en   = 1'b0;
    logic [15:0]      bp_addr = '0;
    logic [15:0]      pc      = '0;
    logic             bp_hit;
`endif

    clock_step_controller_if #(.CNT_W(CNT_W)) cmd_if ();

    clock_step_controller #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd_if),
        .cpu_halt    (cpu_halt),
`ifdef CLOCK_STEP_BREAKPOINT_EN
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc          (pc),
        .bp_hit      (bp_hit),
`endif
        .clk_en      (clk_en),
        .running     (running),
        .done        (done),
        .remaining   (remaining),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Reference: each command yields a known number of ticks, then exactly
    // one done pulse; the debug counter is the running sum of all ticks.
    typedef struct {
        int               ticks;
        logic [CYC_W-1:0] total;
    } exp_t;

    exp_t             exp_q[$];
    logic [CYC_W-1:0] total_m  = '0;
    int               n_cmp    = 0;
    int               n_err    = 0;
    int               tick_obs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_ticks(input int ticks);
        exp_t e;
        total_m = total_m + CYC_W'(ticks);
        e.ticks = ticks;
        e.total = total_m;
        exp_q.push_back(e);
    endtask

    // Monitor: counts ticks and scores every done pulse against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            tick_obs = 0;
        end else begin
            if (clk_en) begin
                tick_obs++;
                check("tick_while_running", running, 1'b1);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done pulse, expected none (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("done_ticks", 64'(tick_obs), 64'(e.ticks));
                    check("done_cycle_count", cycle_count, e.total);
                    check("done_running", running, 1'b0);
                    check("done_clk_en", clk_en, 1'b0);
                    check("done_remaining", remaining, 0);
                end
                tick_obs = 0;
            end
        end
    end

    // Called just after a negedge while halted; returns 1 ns after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_count = cnt;
        #1 check("idle_ready", cmd_if.cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
    endtask

    // how: bit0 = HALT command, bit1 = cpu_halt, applied at the edge ending tick k.
    // pre: cpu_halt already high (and held) when the command is accepted.
    task automatic run_cmd(input logic [1:0] op, input int cnt, input int k, input int how, input bit pre);
        int natural, ticks, seen;
        bit finished, stopping;
        natural = (op == OP_STEP) ? 1 : (op == OP_RUN_N) ? cnt : 1000000;
        if (pre)
            ticks = (natural < 1) ? natural : 1;
        else if (how != 0)
            ticks = (natural < k) ? natural : k;
        else
            ticks = natural;
        expect_ticks(ticks);
        @(negedge clk);
        if (pre) cpu_halt = 1'b1;
        issue(op, CNT_W'(cnt));
        seen     = 0;
        finished = 1'b0;
        for (int i = 0; i < 300 && !finished; i++) begin
            @(negedge clk);
            cmd_if.cmd_valid = 1'b0;
            if (!pre) cpu_halt = 1'b0;
            if (!running) begin
                finished = 1'b1;
            end else begin
                if (clk_en) seen++;
                stopping = !pre && (how != 0) && clk_en && (seen == k);
                if (stopping) begin
                    if ((how & 1) != 0) begin
                        cmd_if.cmd_op    = OP_HALT;
                        cmd_if.cmd_valid = 1'b1;
                        if (op != OP_STEP) #1 check("active_halt_ready", cmd_if.cmd_ready, 1'b1);
                    end
                    if ((how & 2) != 0) cpu_halt = 1'b1;
                end else if (clk_en && seen == 1) begin
                    cmd_if.cmd_op = (op == OP_STEP) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
                    #1 check("busy_ready", cmd_if.cmd_ready, 1'b0);
                end
            end
        end
        cpu_halt         = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        if (!finished) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_timeout: still running after 300 cycles, expected halt");
        end
    endtask

`ifdef CLOCK_STEP_BREAKPOINT_EN
    task automatic bp_test();
        int seen;
        bit fin;
        bp_en   = 1'b1;
        bp_addr = 16'h0004;
        pc      = '0;
        expect_ticks(5);
        @(negedge clk);
        issue(OP_RUN, '0);
        seen = 0;
        fin  = 1'b0;
        for (int i = 0; i < 50 && !fin; i++) begin
            @(negedge clk);
            if (!running) fin = 1'b1;
            else if (clk_en) begin
                pc = 16'(seen);
                seen++;
            end
        end
        check("bp_stopped", fin, 1'b1);
        check("bp_hit_set", bp_hit, 1'b1);
        expect_ticks(2);
        @(negedge clk);
        issue(OP_RUN, '0);
        @(negedge clk);
        check("bp_hit_cleared", bp_hit, 1'b0);
        check("bp_first_tick", clk_en, 1'b1);
        fin = 1'b0;
        for (int i = 0; i < 50 && !fin; i++) begin
            @(negedge clk);
            if (!running) fin = 1'b1;
        end
        check("bp_rerun_stopped", fin, 1'b1);
        check("bp_hit_again", bp_hit, 1'b1);
        bp_en = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int op_sel, cnt, k, how;
        bit pre;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_HALT;
        cmd_if.cmd_count = '0;
        #3;
        check("rst_clk_en", clk_en, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_remaining", remaining, 0);
        check("rst_cycle_count", cycle_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_cmd(OP_STEP, 0, 0, 0, 1'b0);

        expect_ticks(5);
        @(negedge clk);
        issue(OP_RUN_N, 16'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rn5_remaining", remaining, 64'(5 - i));
            check("rn5_clk_en", clk_en, 1'b1);
        end
        @(negedge clk);
        check("rn5_remaining_end", remaining, 0);
        check("rn5_done", done, 1'b1);

        run_cmd(OP_RUN_N, 0, 0, 0, 1'b0);
        run_cmd(OP_RUN, 0, 7, 1, 1'b0);
        run_cmd(OP_RUN_N, 10, 4, 2, 1'b0);
        run_cmd(OP_STEP, 0, 0, 0, 1'b1);
        run_cmd(OP_RUN_N, 3, 3, 3, 1'b0);
        run_cmd(OP_RUN, 0, 0, 0, 1'b1);

        @(negedge clk);
        issue(OP_HALT, '0);
        repeat (3) @(negedge clk);
        check("idle_halt_running", running, 1'b0);

        for (int n = 0; n < 40; n++) begin
            op_sel = $urandom_range(1, 3);
            cnt    = $urandom_range(0, 12);
            k      = $urandom_range(1, 12);
            how    = $urandom_range(0, 3);
            pre    = ($urandom_range(0, 5) == 0);
            if (op_sel == 2 && how == 0 && !pre) how = 2;
            run_cmd(2'(op_sel), cnt, k, how, pre);
        end

`ifdef CLOCK_STEP_BREAKPOINT_EN
        bp_test();
`endif

        @(negedge clk);
        issue(OP_RUN, '0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_clk_en", clk_en, 1'b0);
        check("midrst_running", running, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_remaining", remaining, 0);
        check("midrst_cycle_count", cycle_count, 0);
        total_m = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cmd(OP_STEP, 0, 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
